cla_adder_reg: RTL and testbench
================================

Name: cla_adder_reg

Overview:
- Registered carry-lookahead adder: unsigned sum of two operands, 4-bit lookahead groups with group-level generate/propagate carry chaining.
- One register stage on the result; sits in datapaths that need a timing-closed adder with a known 1-cycle latency.
- Ripple-carry equivalence self-check compiled in optionally for bring-up.

Parameters:
- GROUPS, 8, number of 4-bit lookahead groups; operand width W = 4*GROUPS (default 32); legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  a/b qualify this cycle.
- a  input  W  operand A, unsigned.
- b  input  W  operand B, unsigned.
- out_valid  output  1  s/c hold a new result.
- s  output  W  registered sum, (a+b) mod 2^W.
- c  output  1  registered carry-out, bit W of a+b.
- mismatch  output  1  self-check flag; present only with CLA_RCA_SELFCHECK_EN.

Behaviour:
- Bit level: g[i]=a[i]&b[i], p[i]=a[i]^b[i]; carry-in to bit 0 is 0.
- In-group carries are lookahead, not rippled:
  - c1=g0|p0c0
  - c2=g1|p1g0|p1p0c0
  - c3 and c4 expanded the same way.
- Each group also produces group generate GG and group propagate GP (GP = p3&p2&p1&p0).
- Group carries: C[k+1]=GG[k]|GP[k]&C[k], C[0]=0; C[GROUPS] is the carry-out.
- Sum: s[i]=p[i]^carry[i]. Structure is combinational up to the output register.
- Register stage, on posedge clk:
  - if in_valid: s<=sum, c<=carry-out, out_valid<=1.
  - else: s and c hold, out_valid<=0.
- Latency exactly 1 cycle; throughput 1 result per cycle; no backpressure.
- Reset, asynchronous, takes effect immediately: s=0, c=0, out_valid=0 (mismatch=0). Reset overrides in_valid in the same cycle. First capture happens on the first posedge after rst deasserts.
- Wrap-around: a+b ≥ 2^W gives s=a+b-2^W, c=1. No saturation.
- Boundary values:
  - a=b=0 gives s=0, c=0.
  - all-ones + 1 gives s=0, c=1.
  - all-ones + all-ones gives s=all-ones minus 1, c=1.
- No X propagation from unused paths. Outputs depend only on registered state.

Optional Feature:
- Macro: CLA_RCA_SELFCHECK_EN.
- Defined:
  - Adds a plain ripple-carry adder (full-adder chain, bit 0 carry-in 0) fed by the same a/b.
  - Port mismatch is added. It is registered alongside s and is 1 for the cycle after in_valid when the ripple sum/carry differs from the lookahead sum/carry, else 0.
  - Cleared by rst. Not synthesised for production.
- Not defined:
  - No ripple chain and no mismatch port.
  - All other behaviour identical.

Test Plan:
- Reset: assert rst mid-stream with in_valid=1, a=5, b=7 -> s, c, out_valid go 0 immediately without a clock edge. After release, the next capture gives s=12, c=0, out_valid=1 one cycle later.
- Basic adds, W=32: a=0x00000003, b=0x00000004 -> s=0x00000007, c=0 after 1 cycle. Group-boundary carry: a=0x0000000F, b=0x00000001 -> s=0x00000010, c=0.
- Full carry chain: a=0xFFFFFFFF, b=0x00000001 -> s=0x00000000, c=1. Then a=0xFFFFFFFF, b=0xFFFFFFFF -> s=0xFFFFFFFE, c=1.
- Valid gating: in_valid=1 with a=10, b=20, then in_valid=0 with a=99, b=1 -> s stays 30, out_valid pulses 1 then 0.
- Random: 512 back-to-back uniformly random a/b with in_valid=1 -> each cycle s equals the previous cycle's (a+b) mod 2^32 and c equals its bit 32. Repeat with GROUPS=1 and GROUPS=3.
- Self-check build (CLA_RCA_SELFCHECK_EN): same random 512 vectors -> mismatch stays 0 throughout.

Source files
------------

// File: rtl/cla_adder_reg.sv
// Registered carry-lookahead adder: 4-bit lookahead groups chained on group generate/propagate.
// Define CLA_RCA_SELFCHECK_EN to add a ripple-carry reference and the registered mismatch flag.
module cla_adder_reg #(
    parameter int unsigned GROUPS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [4*GROUPS-1:0]   a,
    input  logic [4*GROUPS-1:0]   b,
    output logic                  out_valid,
    output logic [4*GROUPS-1:0]   s,
    output logic                  c
`ifdef CLA_RCA_SELFCHECK_EN
    ,
    output logic                  mismatch
`endif
);

    localparam int unsigned W = 4 * GROUPS;

    logic [W-1:0]    g;
    logic [W-1:0]    p;
    logic [W-1:0]    carry;
    logic [GROUPS:0] grp_c;
    logic [W-1:0]    sum;

    assign g        = a & b;
    assign p        = a ^ b;
    assign grp_c[0] = 1'b0;

    for (genvar k = 0; k < GROUPS; k++) begin : g_grp
        localparam int unsigned B = 4 * k;
        logic [3:0] gl;
        logic [3:0] pl;
        logic       ci;
        logic       gg;
        logic       gp;

        assign gl = g[B+3:B];
        assign pl = p[B+3:B];
        assign ci = grp_c[k];

        // Every in-group carry is a flat sum of products off the group carry-in.
        assign carry[B]   = ci;
        assign carry[B+1] = gl[0] | (pl[0] & ci);
        assign carry[B+2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & ci);
        assign carry[B+3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                          | (pl[2] & pl[1] & pl[0] & ci);

        assign gg = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                  | (pl[3] & pl[2] & pl[1] & gl[0]);
        assign gp = &pl;

        assign grp_c[k+1] = gg | (gp & ci);
    end

    assign sum = p ^ carry;

    logic [W-1:0] s_q;
    logic [W-1:0] s_d;
    logic         c_q;
    logic         c_d;
    logic         out_valid_q;
    logic         out_valid_d;

    always_comb begin
        s_d         = s_q;
        c_d         = c_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            s_d = sum;
            c_d = grp_c[GROUPS];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q         <= '0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign c         = c_q;
    assign out_valid = out_valid_q;

`ifdef CLA_RCA_SELFCHECK_EN
    logic [W:0]   rc;
    logic [W-1:0] rsum;
    logic         mismatch_q;
    logic         mismatch_d;

    assign rc[0] = 1'b0;
    for (genvar i = 0; i < W; i++) begin : g_rca
        assign rsum[i]  = a[i] ^ b[i] ^ rc[i];
        assign rc[i+1]  = (a[i] & b[i]) | ((a[i] ^ b[i]) & rc[i]);
    end

    assign mismatch_d = in_valid & ((rsum != sum) | (rc[W] != grp_c[GROUPS]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_cla_adder_reg.sv
// Directed-vector and random bench for cla_adder_reg at GROUPS = 8, 3 and 1.
// Build with CLA_RCA_SELFCHECK_EN defined to also watch the mismatch flags.
module tb_cla_adder_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;

    logic        out_valid8, out_valid3, out_valid1;
    logic [31:0] s8;
    logic [11:0] s3;
    logic [3:0]  s1;
    logic        c8, c3, c1;
`ifdef CLA_RCA_SELFCHECK_EN
    logic        mm8, mm3, mm1;
`endif

    int checks = 0;
    int errors = 0;

    cla_adder_reg #(.GROUPS(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid8), .s(s8), .c(c8)
`ifdef CLA_RCA_SELFCHECK_EN
        , .mismatch(mm8)
`endif
    );

    cla_adder_reg #(.GROUPS(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[11:0]), .b(b[11:0]),
        .out_valid(out_valid3), .s(s3), .c(c3)
`ifdef CLA_RCA_SELFCHECK_EN
        , .mismatch(mm3)
`endif
    );

    cla_adder_reg #(.GROUPS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[3:0]), .b(b[3:0]),
        .out_valid(out_valid1), .s(s1), .c(c1)
`ifdef CLA_RCA_SELFCHECK_EN
        , .mismatch(mm1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        c;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [32:0] e33;
        logic [12:0] e13;
        logic [4:0]  e5;

        vecs[0] = '{32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0};
        vecs[1] = '{32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'h1234_5678, 32'h0FED_CBA9, 32'h2222_2221, 1'b0};
        vecs[7] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};

        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'd5;
        b        = 32'd7;
        #1;
        check("reset_s", 64'(s8), 64'h0);
        check("reset_c", 64'(c8), 64'h0);
        check("reset_out_valid", 64'(out_valid8), 64'h0);
`ifdef CLA_RCA_SELFCHECK_EN
        check("reset_mismatch", 64'(mm8), 64'h0);
`endif
        @(posedge clk);
        #1;
        check("reset_overrides_valid_s", 64'(s8), 64'h0);
        check("reset_overrides_valid_ov", 64'(out_valid8), 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_s", i), 64'(s8), 64'(vecs[i].s));
            check($sformatf("vec%0d_c", i), 64'(c8), 64'(vecs[i].c));
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid8), 64'h1);
        end

        // Valid gating: held result, single-cycle out_valid pulse.
        a = 32'd10; b = 32'd20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("gate_s_first", 64'(s8), 64'd30);
        check("gate_ov_first", 64'(out_valid8), 64'h1);
        a = 32'd99; b = 32'd1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("gate_s_hold", 64'(s8), 64'd30);
        check("gate_c_hold", 64'(c8), 64'h0);
        check("gate_ov_drop", 64'(out_valid8), 64'h0);

        // Mid-stream asynchronous reset with a valid input pending.
        a = 32'd5; b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_s", 64'(s8), 64'd12);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_s", 64'(s8), 64'h0);
        check("async_rst_c", 64'(c8), 64'h0);
        check("async_rst_ov", 64'(out_valid8), 64'h0);
        @(posedge clk);
        #1;
        check("held_rst_ov", 64'(out_valid8), 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_s", 64'(s8), 64'd12);
        check("post_rst_c", 64'(c8), 64'h0);
        check("post_rst_ov", 64'(out_valid8), 64'h1);

        for (int i = 0; i < 512; i++) begin
            a = $urandom;
            b = $urandom;
            in_valid = 1'b1;
            e33 = {1'b0, a} + {1'b0, b};
            e13 = {1'b0, a[11:0]} + {1'b0, b[11:0]};
            e5  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d_g8", i), {31'h0, c8, s8}, 64'(e33));
            check($sformatf("rnd%0d_g3", i), {51'h0, c3, s3}, 64'(e13));
            check($sformatf("rnd%0d_g1", i), {59'h0, c1, s1}, 64'(e5));
            check($sformatf("rnd%0d_ov", i), {61'h0, out_valid8, out_valid3, out_valid1}, 64'h7);
`ifdef CLA_RCA_SELFCHECK_EN
            check($sformatf("rnd%0d_mismatch", i), {61'h0, mm8, mm3, mm1}, 64'h0);
`endif
        end

        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("final_ov_drop", {61'h0, out_valid8, out_valid3, out_valid1}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
